// File: rtl/star_scanner.sv
// Raster scanner that reports star pixels (ram_q > THRESHOLD) one at a time to the extent stage.
// Optional feature: define STAR_SCANNER_SKIP_EN to add i_skip_x, which resumes the scan past a reported run.
//
// Handshake: o_star_found pulses for one cycle when a star is captured. The scanner then
// holds o_x_out/o_y_out/o_ram_addr until i_star_done is sampled high in HOLD. i_start is
// honoured only in IDLE or DONE. In HOLD, i_star_done takes priority over i_start.
module star_scanner #(
  parameter int X_RES     = 60,
  parameter int Y_RES     = 60,
  parameter int THRESHOLD = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_star_done,
`ifdef STAR_SCANNER_SKIP_EN
  input  logic [5:0]  i_skip_x,
`endif
  input  logic [2:0]  i_ram_q,
  output logic [11:0] o_ram_addr,
  output logic        o_star_found,
  output logic [5:0]  o_x_out,
  output logic [5:0]  o_y_out,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [2:0]  o_dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_FOUND = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [5:0]  X_LAST   = 6'(X_RES - 1);
  localparam logic [5:0]  Y_LAST   = 6'(Y_RES - 1);
  localparam logic [11:0] ROW_STEP = 12'(X_RES);
  localparam logic [2:0]  THR      = 3'(THRESHOLD);

  logic [2:0]  r_state;
  logic [5:0]  r_x;
  logic [5:0]  r_y;
  logic [11:0] r_row_base;
  logic [5:0]  r_x_out;
  logic [5:0]  r_y_out;

  logic [2:0]  w_state_nxt;
  logic [5:0]  w_x_nxt;
  logic [5:0]  w_y_nxt;
  logic [11:0] w_row_base_nxt;
  logic        w_capture;

  logic        w_hit;
  logic        w_x_end;
  logic        w_last;
  logic [5:0]  w_adv_x;
  logic [5:0]  w_adv_y;
  logic [11:0] w_adv_base;

  assign w_hit   = (i_ram_q > THR);
  assign w_x_end = (r_x == X_LAST);
  assign w_last  = w_x_end && (r_y == Y_LAST);

  // The row base tracks y*X_RES incrementally, so the address needs only one adder.
  assign w_adv_x    = w_x_end ? 6'd0 : (r_x + 6'd1);
  assign w_adv_y    = w_x_end ? (r_y + 6'd1) : r_y;
  assign w_adv_base = w_x_end ? (r_row_base + ROW_STEP) : r_row_base;

  always_comb begin
    w_state_nxt    = r_state;
    w_x_nxt        = r_x;
    w_y_nxt        = r_y;
    w_row_base_nxt = r_row_base;
    w_capture      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_nxt    = S_SCAN;
          w_x_nxt        = 6'd0;
          w_y_nxt        = 6'd0;
          w_row_base_nxt = 12'd0;
        end
      end
      S_SCAN: begin
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_hit) begin
          w_state_nxt = S_FOUND;
          w_capture   = 1'b1;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt    = S_SCAN;
          w_x_nxt        = w_adv_x;
          w_y_nxt        = w_adv_y;
          w_row_base_nxt = w_adv_base;
        end
      end
      S_FOUND: begin
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (i_star_done) begin
`ifdef STAR_SCANNER_SKIP_EN
          // In HOLD the scan counters still sit on the reported pixel (x_out, y_out).
          if (i_skip_x < r_x_out) begin
            if (w_last) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt    = S_SCAN;
              w_x_nxt        = w_adv_x;
              w_y_nxt        = w_adv_y;
              w_row_base_nxt = w_adv_base;
            end
          end else if (i_skip_x >= X_LAST) begin
            if (r_y_out == Y_LAST) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt    = S_SCAN;
              w_x_nxt        = 6'd0;
              w_y_nxt        = r_y_out + 6'd1;
              w_row_base_nxt = r_row_base + ROW_STEP;
            end
          end else begin
            w_state_nxt = S_SCAN;
            w_x_nxt     = i_skip_x + 6'd1;
          end
`else
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt    = S_SCAN;
            w_x_nxt        = w_adv_x;
            w_y_nxt        = w_adv_y;
            w_row_base_nxt = w_adv_base;
          end
`endif
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_x        <= 6'd0;
      r_y        <= 6'd0;
      r_row_base <= 12'd0;
      r_x_out    <= 6'd0;
      r_y_out    <= 6'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_row_base <= w_row_base_nxt;
      if (w_capture) begin
        r_x_out <= r_x;
        r_y_out <= r_y;
      end
    end
  end

  assign o_ram_addr   = r_row_base + {6'd0, r_x};
  assign o_star_found = (r_state == S_FOUND);
  assign o_x_out      = r_x_out;
  assign o_y_out      = r_y_out;
  assign o_busy       = (r_state == S_SCAN) || (r_state == S_CHECK) ||
                        (r_state == S_FOUND) || (r_state == S_HOLD);
  assign o_frame_done = (r_state == S_DONE);
  assign o_dbg_state  = r_state;

endmodule
